// File: rtl/kv_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the key/value store slave port.
// One command in flight at a time; a WAIT-state watchdog aborts and resets the slave.
module kv_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req0_stb,
  input  logic        req0_we,
  input  logic [15:0] req0_adr,
  input  logic [15:0] req0_dat,
  input  logic [15:0] req0_key,
  output logic        req0_ack,
  output logic        req0_err,
  input  logic        req1_stb,
  input  logic        req1_we,
  input  logic [15:0] req1_adr,
  input  logic [15:0] req1_dat,
  input  logic [15:0] req1_key,
  output logic        req1_ack,
  output logic        req1_err,
  output logic [15:0] rsp_dat,
  output logic [1:0]  grant,
  output logic        m_cyc,
  output logic        m_stb,
  output logic        m_we,
  output logic [15:0] m_adr,
  output logic [15:0] m_dat,
  output logic [15:0] m_key,
  output logic        m_rst,
  input  logic        m_ack,
  input  logic [15:0] m_dat_i
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last1_q, last1_d;
  logic        cmd_we_q, cmd_we_d;
  logic [15:0] cmd_adr_q, cmd_adr_d;
  logic [15:0] cmd_dat_q, cmd_dat_d;
  logic [15:0] cmd_key_q, cmd_key_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] rsp_q, rsp_d;
  logic [1:0]  err_q, err_d;
  logic        mrst_q, mrst_d;
  logic        eff0, eff1, pick1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= StIdle;
      grant_q   <= 2'b00;
      last1_q   <= 1'b1;
      cmd_we_q  <= 1'b0;
      cmd_adr_q <= 16'h0;
      cmd_dat_q <= 16'h0;
      cmd_key_q <= 16'h0;
      cnt_q     <= 8'h0;
      rsp_q     <= 16'h0;
      err_q     <= 2'b00;
      mrst_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last1_q   <= last1_d;
      cmd_we_q  <= cmd_we_d;
      cmd_adr_q <= cmd_adr_d;
      cmd_dat_q <= cmd_dat_d;
      cmd_key_q <= cmd_key_d;
      cnt_q     <= cnt_d;
      rsp_q     <= rsp_d;
      err_q     <= err_d;
      mrst_q    <= mrst_d;
    end
  end

  // A requester whose err is pulsing this cycle has not yet seen it, so its
  // still-high strobe is not a new command.
  assign eff0  = req0_stb & ~err_q[0];
  assign eff1  = req1_stb & ~err_q[1];
  assign pick1 = eff1 & (~eff0 | ~last1_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last1_d   = last1_q;
    cmd_we_d  = cmd_we_q;
    cmd_adr_d = cmd_adr_q;
    cmd_dat_d = cmd_dat_q;
    cmd_key_d = cmd_key_q;
    cnt_d     = cnt_q;
    rsp_d     = rsp_q;
    err_d     = 2'b00;
    mrst_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (eff0 | eff1) begin
          cmd_we_d  = pick1 ? req1_we  : req0_we;
          cmd_adr_d = pick1 ? req1_adr : req0_adr;
          cmd_dat_d = pick1 ? req1_dat : req0_dat;
          cmd_key_d = pick1 ? req1_key : req0_key;
          grant_d   = pick1 ? 2'b10 : 2'b01;
          cnt_d     = 8'h0;
          state_d   = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (m_ack) begin
          rsp_d   = m_dat_i;
          state_d = StResp;
        end else if (cnt_q + 8'd1 == TimeoutCnt) begin
          err_d   = grant_q;
          mrst_d  = 1'b1;
          grant_d = 2'b00;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        last1_d = grant_q[1];
        grant_d = 2'b00;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Reads complete only when the slave sees cycle dropped, so cyc stays up in WAIT for writes only.
  assign m_stb    = (state_q == StIssue);
  assign m_cyc    = (state_q == StIssue) | ((state_q == StWait) & cmd_we_q);
  assign m_we     = cmd_we_q;
  assign m_adr    = cmd_adr_q;
  assign m_dat    = cmd_dat_q;
  assign m_key    = cmd_key_q;
  assign m_rst    = mrst_q;
  assign grant    = grant_q;
  assign rsp_dat  = rsp_q;
  assign req0_ack = (state_q == StResp) & grant_q[0];
  assign req1_ack = (state_q == StResp) & grant_q[1];
  assign req0_err = err_q[0];
  assign req1_err = err_q[1];

endmodule
